// File: rtl/bcd_conv_ctrl.sv
// bcd_conv_ctrl: sequential binary-to-BCD converter (shift-add-3 method).
// Optional leading-zero blanking when BCD_CONV_BLANK_EN is defined.
module bcd_conv_ctrl #(
  parameter int BIN_W  = 32,
  parameter int DIGITS = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_W-1:0]      bin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIGITS*4-1:0]   bcd,
  output logic                  busy,
  output logic [DIGITS-1:0]     blank_mask
);

  localparam int W  = DIGITS * 4;
  localparam int CW = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

  state_e           state_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             busy_q;
  logic [BIN_W-1:0] sh_q;
  logic [W-1:0]     acc_q;
  logic [W-1:0]     bcd_q;
  logic [CW-1:0]    cnt_q;

  logic [W-1:0]     acc_adj;
  logic [W-1:0]     acc_d;
  logic [BIN_W-1:0] sh_d;
  logic             last;

  // One shift-add-3 step: correct digits first, then shift the operand MSB in
  always_comb begin
    acc_adj = acc_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5)
        acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
    end
    acc_d = (acc_adj << 1) | W'(sh_q[BIN_W-1]);
    sh_d  = sh_q << 1;
    last  = (cnt_q == CW'(BIN_W - 1));
  end

  // Control FSM with registered handshake outputs and result register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      sh_q        <= '0;
      acc_q       <= '0;
      bcd_q       <= '0;
      cnt_q       <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            sh_q       <= bin;
            acc_q      <= '0;
            cnt_q      <= '0;
            state_q    <= SHIFT;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        SHIFT: begin
          acc_q <= acc_d;
          sh_q  <= sh_d;
          cnt_q <= cnt_q + CW'(1);
          if (last) begin
            state_q     <= DONE;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b1;
            bcd_q       <= acc_d;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign bcd       = bcd_q;

`ifdef BCD_CONV_BLANK_EN
  logic [DIGITS-1:0] blank_d;
  logic [DIGITS-1:0] blank_q;
  logic              zero_run;

  // Digit i is blank when it and every higher digit are zero; digit 0 never
  always_comb begin
    blank_d  = '0;
    zero_run = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_run   = zero_run & (acc_d[4*i +: 4] == 4'd0);
      blank_d[i] = zero_run;
    end
  end

  // Blank mask is captured on the same edge as the result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      blank_q <= '0;
    else if (state_q == SHIFT && last)
      blank_q <= blank_d;
  end

  assign blank_mask = blank_q;
`else
  assign blank_mask = '0;
`endif

endmodule

// File: tb/tb_bcd_conv_ctrl.sv
// tb_bcd_conv_ctrl: randomized self-checking bench for bcd_conv_ctrl.
// Expected values come from decimal arithmetic on the operand.
module tb_bcd_conv_ctrl;

  localparam int BIN_W  = 32;
  localparam int DIGITS = 10;
  localparam int W      = DIGITS * 4;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [BIN_W-1:0]  bin;
  logic              out_valid;
  logic              out_ready;
  logic [W-1:0]      bcd;
  logic              busy;
  logic [DIGITS-1:0] blank_mask;

  int checks;
  int errors;

  bcd_conv_ctrl #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .bin        (bin),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .bcd        (bcd),
    .busy       (busy),
    .blank_mask (blank_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] ref_bcd(input logic [BIN_W-1:0] v);
    longint unsigned n;
    logic [W-1:0] r;
    n = longint'(v);
    r = '0;
    for (int d = 0; d < DIGITS; d++) begin
      r[4*d +: 4] = 4'(n % 10);
      n = n / 10;
    end
    return r;
  endfunction

  function automatic logic [DIGITS-1:0] ref_blank(input logic [BIN_W-1:0] v);
    logic [DIGITS-1:0] m;
    longint unsigned p;
    m = '0;
`ifdef BCD_CONV_BLANK_EN
    p = 1;
    for (int i = 1; i < DIGITS; i++) begin
      p = p * 10;
      m[i] = (longint'(v) < p);
    end
`else
    p = 0;
    if (p != 0) m = '1;
`endif
    return m;
  endfunction

  task automatic start(input logic [BIN_W-1:0] v);
    in_valid = 1'b1;
    bin      = v;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat, output int bcnt);
    lat  = 0;
    bcnt = busy ? 1 : 0;
    while (lat < 100) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
      if (busy) bcnt++;
      if (out_valid) break;
    end
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    bin = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({in_ready, out_valid, busy} !== 3'b100 || bcd !== '0
        || blank_mask !== '0) begin
      errors++;
      $display("FAIL reset: rdy/vld/busy=%b bcd=%h mask=%b want 100 0 0",
               {in_ready, out_valid, busy}, bcd, blank_mask);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_zero();
    int lat, bc;
    start('0);
    wait_out(lat, bc);
    checks++;
    if (lat !== 32 || bcd !== ref_bcd('0) || blank_mask !== ref_blank('0)) begin
      errors++;
      $display("FAIL zero: lat=%0d bcd=%h mask=%b want 32 %h %b",
               lat, bcd, blank_mask, ref_bcd('0), ref_blank('0));
    end
    release_result();
  endtask

  task automatic test_max();
    int lat, bc;
    logic [W-1:0] exp;
    exp = 40'h4294967295;
    start(32'hFFFFFFFF);
    wait_out(lat, bc);
    checks++;
    if (lat !== 32 || bc !== 32 || bcd !== exp) begin
      errors++;
      $display("FAIL max: lat=%0d busy_cyc=%0d bcd=%h want 32 32 %h",
               lat, bc, bcd, exp);
    end
    checks++;
    if (blank_mask !== ref_blank(32'hFFFFFFFF)) begin
      errors++;
      $display("FAIL max_mask: got %b want %b", blank_mask,
               ref_blank(32'hFFFFFFFF));
    end
    release_result();
  endtask

  task automatic test_random();
    int lat, bc;
    logic [BIN_W-1:0] v;
    for (int k = 0; k < 10; k++) begin
      v = (k % 2 == 0) ? BIN_W'($urandom) : BIN_W'($urandom_range(0, 99999));
      start(v);
      wait_out(lat, bc);
      checks++;
      if (lat !== 32 || bcd !== ref_bcd(v) || blank_mask !== ref_blank(v)) begin
        errors++;
        $display("FAIL random v=%0d: lat=%0d bcd=%h mask=%b want 32 %h %b",
                 v, lat, bcd, blank_mask, ref_bcd(v), ref_blank(v));
      end
      release_result();
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || bcd !== ref_bcd(v)) begin
        errors++;
        $display("FAIL random_idle: rdy=%b vld=%b bcd=%h want 1 0 %h",
                 in_ready, out_valid, bcd, ref_bcd(v));
      end
    end
  endtask

  task automatic test_hold();
    int lat, bc;
    int bad;
    start(32'd1234);
    wait_out(lat, bc);
    checks++;
    if (lat !== 32 || bcd !== 40'h0000001234) begin
      errors++;
      $display("FAIL hold_result: lat=%0d bcd=%h want 32 0000001234", lat, bcd);
    end
    bad = 0;
    in_valid = 1'b1;
    bin = 32'd55;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b0
          || bcd !== 40'h0000001234) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL hold_stable: bad_cycles=%0d want 0", bad);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || bcd !== 40'h0000001234) begin
      errors++;
      $display("FAIL hold_release: rdy=%b vld=%b bcd=%h want 1 0 0000001234",
               in_ready, out_valid, bcd);
    end
  endtask

  task automatic test_ignore();
    int lat, bc;
    start(32'd7);
    bin = 32'd99;
    for (int c = 0; c < 12; c++) begin
      in_valid = ~in_valid;
      @(negedge clk);
    end
    in_valid = 1'b0;
    wait_out(lat, bc);
    checks++;
    if (lat !== 20 || bcd !== 40'h0000000007) begin
      errors++;
      $display("FAIL ignore: remaining_lat=%0d bcd=%h want 20 0000000007",
               lat, bcd);
    end
    release_result();
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ignore_idle: rdy=%b busy=%b want 1 0", in_ready, busy);
    end
  endtask

  task automatic test_reset_abort();
    int lat, bc;
    logic [BIN_W-1:0] v;
    v = BIN_W'($urandom);
    start(BIN_W'($urandom));
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || bcd !== '0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort: vld=%b busy=%b bcd=%h rdy=%b want 0 0 0 1",
               out_valid, busy, bcd, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    start(v);
    wait_out(lat, bc);
    checks++;
    if (lat !== 32 || bcd !== ref_bcd(v)) begin
      errors++;
      $display("FAIL abort_restart: lat=%0d bcd=%h want 32 %h",
               lat, bcd, ref_bcd(v));
    end
    release_result();
  endtask

  task automatic test_back_to_back();
    int lat, bc;
    out_ready = 1'b1;
    start(32'd10);
    in_valid = 1'b1;
    bin = 32'd100;
    wait_out(lat, bc);
    checks++;
    if (lat !== 32 || bcd !== 40'h10 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_first: lat=%0d bcd=%h rdy=%b want 32 10 0",
               lat, bcd, in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle: rdy=%b vld=%b busy=%b want 1 0 0",
               in_ready, out_valid, busy);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    wait_out(lat, bc);
    checks++;
    if (lat !== 32 || bc !== 32 || bcd !== 40'h100) begin
      errors++;
      $display("FAIL b2b_second: lat=%0d busy_cyc=%0d bcd=%h want 32 32 100",
               lat, bc, bcd);
    end
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    @(negedge clk);
    test_zero();
    test_max();
    test_random();
    test_hold();
    test_ignore();
    test_reset_abort();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
